// File: rtl/aibcr3_txbuf_seq.sv
// Power-up and mode sequencer for one AIB I/O buffer.
// Ramps tx drive in timed steps and switches off/tx/rx modes without glitches.
module aibcr3_txbuf_seq #(
  parameter int SETTLE_CYC  = 16,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       por_aib_vcchssi,
  input  logic       cfg_req,
  input  logic [1:0] cfg_mode,
  input  logic [1:0] cfg_drv,
  input  logic       tx_data,
  output logic       busy,
  output logic       cfg_ack,
  output logic       itx_en_buf,
  output logic       data_en,
  output logic       clk_en,
  output logic       weak_pulldownen,
  output logic       weak_pullupenb,
  output logic [1:0] ipdrv_buf,
  output logic [1:0] indrv_buf,
  output logic       txdin
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRECHG,
    S_RAMP_UP,
    S_ACTIVE,
    S_RAMP_DN
  } state_t;

  localparam logic [1:0] M_OFF = 2'b00;
  localparam logic [1:0] M_TX  = 2'b01;
  localparam logic [CNT_W-1:0] LOAD =
    CNT_W'(SETTLE_CYC - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_por;

  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [1:0]       r_drv, w_drv;
  logic [1:0]       r_tgt, w_tgt;
  logic [1:0]       r_mode, w_mode;
  logic             r_itx, w_itx;
  logic             r_den, w_den;
  logic             r_cen, w_cen;
  logic             r_wpd, w_wpd;
  logic             r_txd, w_txd;
  logic             r_busy, w_busy;
  logic             r_ack, w_ack;

  logic             w_iv_end;
  logic             w_accept;
  logic [1:0]       w_pc_mode;
  logic             w_same;

  // POR synchronizer into the clk domain
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], por_aib_vcchssi};
    end
  end

  assign w_por = r_sync[SYNC_STAGES-1];

  assign w_iv_end  = (r_cnt == '0);
  assign w_accept  = cfg_req && !r_busy;
  assign w_pc_mode = r_busy ? r_mode : cfg_mode;
  assign w_same    = (cfg_mode == r_mode) &&
                     ((cfg_mode != M_TX) ||
                      (cfg_drv == r_tgt));

  // State and output registers; POR holds everything at reset values
  always_ff @(posedge clk) begin
    if (reset || w_por) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_drv   <= 2'd0;
      r_tgt   <= 2'd0;
      r_mode  <= M_OFF;
      r_itx   <= 1'b0;
      r_den   <= 1'b0;
      r_cen   <= 1'b0;
      r_wpd   <= 1'b1;
      r_txd   <= 1'b0;
      r_busy  <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_drv   <= w_drv;
      r_tgt   <= w_tgt;
      r_mode  <= w_mode;
      r_itx   <= w_itx;
      r_den   <= w_den;
      r_cen   <= w_cen;
      r_wpd   <= w_wpd;
      r_txd   <= w_txd;
      r_busy  <= w_busy;
      r_ack   <= w_ack;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state = r_state;
    w_cnt   = w_iv_end ? r_cnt : r_cnt - 1'b1;
    w_drv   = r_drv;
    w_tgt   = r_tgt;
    w_mode  = r_mode;
    w_itx   = r_itx;
    w_den   = r_den;
    w_cen   = r_cen;
    w_wpd   = r_wpd;
    w_txd   = r_txd;
    w_busy  = r_busy;
    w_ack   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_busy && r_mode == M_OFF) begin
          w_ack  = 1'b1;
          w_busy = 1'b0;
        end else if (r_busy || w_accept) begin
          if (!r_busy) begin
            w_mode = cfg_mode;
            w_tgt  = cfg_drv;
          end
          if (w_pc_mode == M_OFF) begin
            w_ack = 1'b1;
          end else begin
            w_state = S_PRECHG;
            w_busy  = 1'b1;
            w_cnt   = LOAD;
            w_den   = w_pc_mode[1];
            w_cen   = w_pc_mode[1];
            w_wpd   = w_pc_mode[1] ?
                      w_pc_mode[0] : 1'b1;
          end
        end
      end
      S_PRECHG: begin
        if (w_iv_end) begin
          w_cnt = LOAD;
          if (r_mode == M_TX) begin
            w_state = S_RAMP_UP;
            w_itx   = 1'b1;
            w_wpd   = 1'b0;
            w_drv   = 2'd0;
          end else begin
            w_state = S_ACTIVE;
            w_ack   = 1'b1;
            w_busy  = 1'b0;
          end
        end
      end
      S_RAMP_UP: begin
        if (w_iv_end) begin
          w_cnt = LOAD;
          if (r_drv == r_tgt) begin
            w_state = S_ACTIVE;
            w_ack   = 1'b1;
            w_busy  = 1'b0;
          end else begin
            w_drv = r_drv + 2'd1;
          end
        end
      end
      S_ACTIVE: begin
        if (r_mode == M_TX) begin
          w_txd = tx_data;
        end
        if (w_accept) begin
          if (w_same) begin
            w_ack = 1'b1;
          end else begin
            w_busy = 1'b1;
            w_mode = cfg_mode;
            w_tgt  = cfg_drv;
            w_cnt  = LOAD;
            if (r_mode == M_TX) begin
              w_state = S_RAMP_DN;
              w_txd   = 1'b0;
            end else begin
              w_state = S_IDLE;
              w_den   = 1'b0;
              w_cen   = 1'b0;
              w_wpd   = 1'b1;
            end
          end
        end
      end
      S_RAMP_DN: begin
        if (w_iv_end) begin
          w_cnt = LOAD;
          if (r_drv == 2'd0) begin
            w_state = S_IDLE;
            w_itx   = 1'b0;
            w_wpd   = 1'b1;
          end else begin
            w_drv = r_drv - 2'd1;
          end
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign busy            = r_busy;
  assign cfg_ack         = r_ack;
  assign itx_en_buf      = r_itx;
  assign data_en         = r_den;
  assign clk_en          = r_cen;
  assign weak_pulldownen = r_wpd;
  assign weak_pullupenb  = 1'b1;
  assign ipdrv_buf       = r_drv;
  assign indrv_buf       = r_drv;
  assign txdin           = r_txd;

endmodule

// File: tb/tb_aibcr3_txbuf_seq.sv
// Bench for aibcr3_txbuf_seq with SETTLE_CYC=4.
// Ack scoreboard plus directed trajectory checks.
module tb_aibcr3_txbuf_seq;

  logic       clk;
  logic       reset;
  logic       por_aib_vcchssi;
  logic       cfg_req;
  logic [1:0] cfg_mode;
  logic [1:0] cfg_drv;
  logic       tx_data;
  logic       busy;
  logic       cfg_ack;
  logic       itx_en_buf;
  logic       data_en;
  logic       clk_en;
  logic       weak_pulldownen;
  logic       weak_pullupenb;
  logic [1:0] ipdrv_buf;
  logic [1:0] indrv_buf;
  logic       txdin;

  aibcr3_txbuf_seq #(
    .SETTLE_CYC (4),
    .CNT_W      (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .por_aib_vcchssi(por_aib_vcchssi),
    .cfg_req        (cfg_req),
    .cfg_mode       (cfg_mode),
    .cfg_drv        (cfg_drv),
    .tx_data        (tx_data),
    .busy           (busy),
    .cfg_ack        (cfg_ack),
    .itx_en_buf     (itx_en_buf),
    .data_en        (data_en),
    .clk_en         (clk_en),
    .weak_pulldownen(weak_pulldownen),
    .weak_pullupenb (weak_pullupenb),
    .ipdrv_buf      (ipdrv_buf),
    .indrv_buf      (indrv_buf),
    .txdin          (txdin)
  );

  typedef struct {
    int         cyc;
    logic [1:0] drv;
    logic       itx;
    logic       de;
    logic       ce;
    logic       wpd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   r;
  logic [7:0] pat = 8'hB2;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d want %0d",
               nm, cyc, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(int c, logic [1:0] d, logic i,
                      logic de, logic ce, logic w);
    exp_t e;
    e.cyc = c; e.drv = d; e.itx = i;
    e.de = de; e.ce = ce; e.wpd = w;
    q.push_back(e);
  endtask

  task automatic req(logic [1:0] m, logic [1:0] d);
    cfg_req  = 1'b1;
    cfg_mode = m;
    cfg_drv  = d;
    tick(1);
    cfg_req  = 1'b0;
  endtask

  task automatic chk_rst_vals(string tag);
    chk({tag, "_itx"}, itx_en_buf, 0);
    chk({tag, "_de"}, data_en, 0);
    chk({tag, "_ce"}, clk_en, 0);
    chk({tag, "_wpd"}, weak_pulldownen, 1);
    chk({tag, "_wpu"}, weak_pullupenb, 1);
    chk({tag, "_pdrv"}, ipdrv_buf, 0);
    chk({tag, "_ndrv"}, indrv_buf, 0);
    chk({tag, "_txd"}, txdin, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ack"}, cfg_ack, 0);
  endtask

  // Ack monitor: every ack must match the oldest expectation
  always @(negedge clk) begin
    if (!reset && cfg_ack) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack at cycle %0d: got ack want none",
                 cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ack_cycle", cyc, e.cyc);
        chk("ack_busy", busy, 0);
        chk("ack_drv", ipdrv_buf, e.drv);
        chk("ack_ndrv", indrv_buf, e.drv);
        chk("ack_itx", itx_en_buf, e.itx);
        chk("ack_de", data_en, e.de);
        chk("ack_ce", clk_en, e.ce);
        chk("ack_wpd", weak_pulldownen, e.wpd);
      end
    end
  end

  initial begin
    reset = 1'b1;
    por_aib_vcchssi = 1'b0;
    cfg_req = 1'b0;
    cfg_mode = 2'b00;
    cfg_drv = 2'b00;
    tx_data = 1'b0;
    tick(3);
    chk_rst_vals("rst");
    reset = 1'b0;
    tick(2);

    // tx from IDLE, drive 2
    r = cyc;
    push(r + 17, 2'd2, 1, 0, 0, 0);
    req(2'b01, 2'd2);
    for (int k = 1; k <= 16; k++) begin
      chk("up_busy", busy, 1);
      chk("up_drv", ipdrv_buf, (k < 5) ? 0 : (k - 5) / 4);
      chk("up_itx", itx_en_buf, (k >= 5) ? 1 : 0);
      chk("up_wpd", weak_pulldownen, (k >= 5) ? 0 : 1);
      tick(1);
    end
    for (int i = 0; i < 8; i++) begin
      tx_data = pat[i];
      tick(1);
      chk("txdin_follow", txdin, pat[i]);
    end
    tx_data = 1'b1;
    tick(1);

    // request for current tx mode and drive
    r = cyc;
    push(r + 1, 2'd2, 1, 0, 0, 0);
    req(2'b01, 2'd2);
    chk("same_busy", busy, 0);
    chk("same_drv", ipdrv_buf, 2);
    chk("same_itx", itx_en_buf, 1);
    tick(2);

    // ACTIVE tx d=2 -> rx 10, ignored request while busy
    r = cyc;
    push(r + 18, 2'd0, 0, 1, 1, 0);
    req(2'b10, 2'd0);
    for (int k = 1; k <= 17; k++) begin
      chk("dn_busy", busy, 1);
      chk("dn_txd", txdin, 0);
      chk("dn_drv", ipdrv_buf, (k <= 4) ? 2 : (k <= 8) ? 1 : 0);
      chk("dn_itx", itx_en_buf, (k <= 12) ? 1 : 0);
      chk("dn_de", data_en, (k >= 14) ? 1 : 0);
      if (k == 6) begin
        cfg_req = 1'b1;
        cfg_mode = 2'b00;
      end else begin
        cfg_req = 1'b0;
      end
      tick(1);
    end
    tick(2);

    // rx 10 -> off via IDLE
    r = cyc;
    push(r + 2, 2'd0, 0, 0, 0, 1);
    req(2'b00, 2'd0);
    chk("rxoff_busy", busy, 1);
    chk("rxoff_de", data_en, 0);
    tick(3);

    // rx 11 from IDLE
    r = cyc;
    push(r + 5, 2'd0, 0, 1, 1, 1);
    req(2'b11, 2'd0);
    for (int k = 1; k <= 4; k++) begin
      chk("rx11_de", data_en, 1);
      chk("rx11_ce", clk_en, 1);
      chk("rx11_wpd", weak_pulldownen, 1);
      chk("rx11_busy", busy, 1);
      tick(1);
    end
    tick(2);

    // rx 11 -> off, then off from IDLE
    r = cyc;
    push(r + 2, 2'd0, 0, 0, 0, 1);
    req(2'b00, 2'd0);
    tick(3);
    r = cyc;
    push(r + 1, 2'd0, 0, 0, 0, 1);
    req(2'b00, 2'd0);
    chk("off_busy", busy, 0);
    tick(2);

    // POR during RAMP_UP
    req(2'b01, 2'd3);
    tick(6);
    chk("por_pre_itx", itx_en_buf, 1);
    por_aib_vcchssi = 1'b1;
    tick(3);
    chk_rst_vals("por");
    req(2'b01, 2'd1);
    tick(3);
    chk_rst_vals("por_hold");
    por_aib_vcchssi = 1'b0;
    tick(4);
    chk("post_por_busy", busy, 0);
    r = cyc;
    push(r + 13, 2'd1, 1, 0, 0, 0);
    req(2'b01, 2'd1);
    tick(15);

    chk("pending_acks", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aibcr3_txbuf_seq.md
# aibcr3_txbuf_seq

Power-up and mode sequencer for one AIB I/O buffer. It sits directly upstream of the `aibcr3_analog` pad cell and drives that cell's control and data inputs: `itx_en_buf`, `data_en`, `clk_en`, `ipdrv_buf`, `indrv_buf`, `weak_pullupenb`, `weak_pulldownen` and `txdin`. It switches the pad between off, transmit and receive modes without glitches. Transmit drive strength is ramped up and down in timed steps, and the sequence is aborted immediately while the `por_aib_vcchssi` power-on reset is asserted.

## Interface

Parameters:
- `SETTLE_CYC`, default 16: cycles per settle interval; legal range 1..255.
- `CNT_W`, default 8: width of the interval counter; must satisfy 2^CNT_W > SETTLE_CYC.
- `SYNC_STAGES`, default 2: number of flops in the `por_aib_vcchssi` synchronizer; minimum 2.

Ports:
- `clk` in 1: block clock.
- `reset` in 1: synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `por_aib_vcchssi` in 1: asynchronous power-on reset, active-high. Synchronized internally.
- `cfg_req` in 1: single-cycle mode-change request.
- `cfg_mode` in 2: requested mode, sampled with `cfg_req`. 00 = off, 01 = tx, 10 = rx, 11 = rx with weak pulldown.
- `cfg_drv` in 2: target tx drive strength, sampled with `cfg_req`.
- `tx_data` in 1: transmit data bit.
- `busy` out 1: a sequence is in progress; `cfg_req` is ignored while this is high.
- `cfg_ack` out 1: one-cycle pulse when the requested mode is reached.
- `itx_en_buf`, `data_en`, `clk_en`, `weak_pulldownen` out 1: pad control outputs.
- `weak_pullupenb` out 1: weak pull-up enable, active-low. Constant 1 in this block.
- `ipdrv_buf`, `indrv_buf` out 2: pad drive strength. Both always carry the same value, `drv`.
- `txdin` out 1: registered transmit data to the pad.

## Operation

- All outputs are registered.
- States: IDLE, PRECHG, RAMP_UP, ACTIVE, RAMP_DN.
- Interval counter: loads `SETTLE_CYC-1` on every state entry and on every drive step, then counts down. An interval ends when the counter reaches 0.
- Reset values: state IDLE; `drv`=0; `itx_en_buf`=`data_en`=`clk_en`=`txdin`=`busy`=`cfg_ack`=0; `weak_pulldownen`=1; `weak_pullupenb`=1; stored mode = off.

IDLE:
- All enables are 0 and `weak_pulldownen`=1.
- An accepted request with mode 01, 10 or 11 goes to PRECHG and sets `busy`.
- An accepted request with mode 00 pulses `cfg_ack` on the next cycle and stays in IDLE.

PRECHG (one interval):
- tx: keep `weak_pulldownen`=1.
- rx: assert `data_en`=`clk_en`=1. `weak_pulldownen` is 1 for mode 11 and 0 for mode 10.
- At interval end: tx goes to RAMP_UP; rx goes to ACTIVE.

RAMP_UP (tx only):
- On entry: `itx_en_buf`=1, `weak_pulldownen`=0, `drv`=0.
- At each interval end: if `drv` equals the target, go to ACTIVE; otherwise `drv`+1.
- Duration is (target+1)·`SETTLE_CYC` cycles.

ACTIVE:
- On entry: pulse `cfg_ack` and clear `busy`.
- tx: `txdin` <= `tx_data`, one-cycle latency.
- An accepted request for the current mode (same mode and, for tx, same `cfg_drv`) pulses `cfg_ack` on the next cycle with no other change.
- Any other request sets `busy` and stores the new mode and drive target. tx then goes to RAMP_DN; rx goes to IDLE.

RAMP_DN:
- `txdin` is forced to 0 in the first RAMP_DN cycle.
- At each interval end: if `drv`=0, go to IDLE and clear `itx_en_buf`; otherwise `drv`-1.

Returning to IDLE with a pending mode:
- Pending mode 00: pulse `cfg_ack` and clear `busy`.
- Otherwise go straight to PRECHG. No ack is issued for the intermediate IDLE.

Synchronized POR (`por_sync`):
- While `por_sync`=1, all state is held at the reset values from the next cycle onward.
- Any pending request is dropped, no `cfg_ack` is issued, and `cfg_req` is ignored.
- When POR deasserts mid-sequence, the block resumes from IDLE with mode off.

Simultaneous events:
- `reset` has priority over `por_sync`; `por_sync` has priority over `cfg_req`.
- A `cfg_req` in the same cycle that `cfg_ack` is high is accepted, because `busy` is already 0.

## Timing

- Request latency is measured from the `cfg_req` cycle r to the `cfg_ack` cycle:
  - tx from IDLE: r + 1 + `SETTLE_CYC`·(target+2).
  - rx from IDLE: r + 1 + `SETTLE_CYC`.
  - Off, or a request for the current mode: r + 1.
- tx to off from ACTIVE with drive d: IDLE is reached at r + 1 + (d+1)·`SETTLE_CYC`, and `cfg_ack` pulses in the cycle after IDLE is entered.
- POR synchronizer latency is `SYNC_STAGES` cycles, plus 1 cycle for the outputs to reach their reset values.
- `busy` rises in cycle r+1 and falls in the same cycle `cfg_ack` pulses.
- `txdin` changes only in ACTIVE(tx), or when it is forced to 0. It never toggles while `itx_en_buf`=0.

## Test plan

All cases use `SETTLE_CYC`=4 and the request at cycle r=0.

- Reset, then tx request with `cfg_drv`=2:
  - PRECHG in cycles 1–4.
  - `drv` is 0 in cycles 5–8, 1 in cycles 9–12, 2 in cycles 13–16.
  - `cfg_ack` pulses in cycle 17, `busy` is high in cycles 1–16, and `txdin` follows `tx_data` one cycle later from then on.
- rx mode 11: `data_en`=`clk_en`=1 from cycle 1 and `weak_pulldownen` stays 1; `cfg_ack` pulses in cycle 5.
- Switch from ACTIVE tx (d=2) to rx 10: `txdin` is 0 from cycle 1, `drv` steps 2→1→0 at 4-cycle intervals, IDLE is entered at cycle 13, PRECHG follows, and `cfg_ack` pulses at 13+1+4.
- `cfg_req` pulsed while `busy`=1: the request is ignored, with no change to the sequence or its ack timing.
- `por_aib_vcchssi` asserted during RAMP_UP: after `SYNC_STAGES`+1 cycles all outputs hold their reset values, no `cfg_ack` is issued, and a request made after POR deasserts completes normally.
- Request for the current tx mode and drive while ACTIVE: `cfg_ack` pulses in cycle 1 and `drv` and `itx_en_buf` are unchanged.
